// File: rtl/prog_clk_divider_pkg.sv
// Shared definitions for the programmable clock divider: mode encoding,
// config FSM state encoding and the channel-index width helper.
package prog_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_e;

  // Channel index width; a single channel still needs one address bit.
  function automatic int CH_W(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Config request port of the divider: valid/ready handshake carrying the
// target channel, divisor and mode, plus the out-of-range error strobe.
interface prog_clk_divider_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 24
) ();
  import prog_div_pkg::*;

  localparam int CHB = CH_W(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHB-1:0]   cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_mode,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_mode,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/prog_clk_divider_div_channel.sv
// One divider channel: counter, divisor/mode registers and the registered
// fdiv/tick outputs. A load restarts the channel from count 0 with fdiv low.
module div_channel
  import prog_div_pkg::*;
#(
  parameter int CNT_W    = 24,
  parameter int DEF_DIV  = 80000,
  parameter int DEF_MODE = 0
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_mode,
  output logic             fdiv,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_L  = CNT_W'(DEF_DIV);
  localparam logic             DEF_MODE_L = (DEF_MODE != 0) ? MODE_PULSE : MODE_TOGGLE;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_r;
  logic             mode_r;
  logic             term_s;

  // Terminal count: full-width compare against div-1 (only meaningful for div!=0).
  always_comb begin
    term_s = 1'b0;
    if (div_r != '0) begin
      term_s = (cnt_r == (div_r - CNT_W'(1)));
    end else begin
      term_s = 1'b0;
    end
  end

  // Counter, configuration and output registers; a load wins over any terminal count.
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      cnt_r  <= '0;
      div_r  <= DEF_DIV_L;
      mode_r <= DEF_MODE_L;
      fdiv   <= 1'b0;
      tick   <= 1'b0;
    end else if (load) begin
      cnt_r  <= '0;
      div_r  <= load_div;
      mode_r <= load_mode;
      fdiv   <= 1'b0;
      tick   <= 1'b0;
    end else if (div_r == '0) begin
      cnt_r  <= '0;
      fdiv   <= 1'b0;
      tick   <= 1'b0;
    end else if (!en) begin
      tick   <= 1'b0;
    end else if (term_s) begin
      cnt_r  <= '0;
      tick   <= 1'b1;
      fdiv   <= (mode_r == MODE_PULSE) ? 1'b1 : ~fdiv;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      tick   <= 1'b0;
      fdiv   <= (mode_r == MODE_PULSE) ? 1'b0 : fdiv;
    end
  end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock-enable/divider. Holds the two-state config
// FSM, channel address decode and cfg_err; each channel is a div_channel.
module prog_clk_divider
  import prog_div_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 24,
  parameter int DEF_DIV  = 80000,
  parameter int DEF_MODE = 0
) (
  input  logic            clk_50,
  input  logic            rst,
  input  logic            en,
  prog_clk_divider_if.slave cfg,
  output logic [N_CH-1:0] fdiv,
  output logic [N_CH-1:0] tick
);

  localparam int            CHB    = CH_W(N_CH);
  localparam logic [CHB:0]  N_CH_L = (CHB + 1)'(N_CH);

  cfg_state_e       state_r;
  cfg_state_e       state_s;
  logic             accept_s;
  logic             cfg_ready_s;
  logic             cfg_err_s;
  logic             cfg_ready_r;
  logic             cfg_err_r;
  logic [CHB-1:0]   ch_r;
  logic             ch_ok_r;
  logic [CNT_W-1:0] div_r;
  logic             mode_r;
  logic [N_CH-1:0]  load_s;

  // Config FSM next state plus next values of the registered ready/error outputs.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg.cfg_valid && cfg_ready_r) begin
          accept_s = 1'b1;
          state_s  = APPLY;
        end else begin
          state_s  = IDLE;
        end
      end
      APPLY:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
    cfg_ready_s = (state_s == IDLE);
    cfg_err_s   = accept_s && ({1'b0, cfg.cfg_ch} >= N_CH_L);
  end

  // Config FSM state register, output registers and the latched request.
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= 1'b0;
      ch_r        <= '0;
      ch_ok_r     <= 1'b0;
      div_r       <= '0;
      mode_r      <= MODE_TOGGLE;
    end else begin
      state_r     <= state_s;
      cfg_ready_r <= cfg_ready_s;
      cfg_err_r   <= cfg_err_s;
      if (accept_s) begin
        ch_r    <= cfg.cfg_ch;
        ch_ok_r <= ({1'b0, cfg.cfg_ch} < N_CH_L);
        div_r   <= cfg.cfg_div;
        mode_r  <= cfg.cfg_mode;
      end else begin
        ch_r    <= ch_r;
        ch_ok_r <= ch_ok_r;
        div_r   <= div_r;
        mode_r  <= mode_r;
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;
  assign cfg.cfg_err   = cfg_err_r;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Only the addressed, in-range channel restarts during APPLY.
    assign load_s[i] = (state_r == APPLY) && ch_ok_r && (ch_r == CHB'(i));

    div_channel #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_MODE (DEF_MODE)
    ) u_ch (
      .clk_50    (clk_50),
      .rst       (rst),
      .en        (en),
      .load      (load_s[i]),
      .load_div  (div_r),
      .load_mode (mode_r),
      .fdiv      (fdiv[i]),
      .tick      (tick[i])
    );
  end

endmodule
